// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: RISC-V width codes, FSM states
// and the alignment masks used to classify erroring requests.
package dmem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] HALF_ALIGN_MASK = 2'b01;
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
    localparam int         WORD_LSB        = 2;
    localparam int         CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Width/alignment legality only; the range check needs DEPTH_WORDS and lives in the top.
    function automatic logic width_err(input logic write, input logic [2:0] funct3,
                                       input logic [1:0] lsb);
        logic e;
        case (funct3)
            F3_B:    e = 1'b0;
            F3_H:    e = |(lsb & HALF_ALIGN_MASK);
            F3_W:    e = |(lsb & WORD_ALIGN_MASK);
            F3_BU:   e = write;
            F3_HU:   e = write | (|(lsb & HALF_ALIGN_MASK));
            default: e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte-lane write enables and a combinational read.
// Single shared address for read and write; contents are never reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated load/store responder: accepts one request, commits it WAIT_CYCLES+1 edges later,
// then holds the response until rsp_ready; no new request is taken until the response drains.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int ADDR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               q_write;
    logic [31:0]        q_addr;
    logic [31:0]        q_wdata;
    logic [2:0]         q_funct3;
    logic               accept, commit;
    logic               acc_err, range_err;
    logic [31:0]        word_idx;
    logic [31:0]        rd_word, rd_shift, load_data, st_data;
    logic [15:0]        rd_half;
    logic [3:0]         st_be, arr_we;

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept   = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    commit   = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);

    assign word_idx  = 32'(q_addr[31:WORD_LSB]);
    assign range_err = (word_idx >= 32'(DEPTH_WORDS));
    assign acc_err   = range_err | width_err(q_write, q_funct3, q_addr[1:0]);

    // Lane placement: replicate the right-aligned data and let the byte enables pick lanes.
    always_comb begin
        st_data = q_wdata;
        st_be   = 4'b1111;
        case (q_funct3)
            F3_B: begin
                st_data = {4{q_wdata[7:0]}};
                st_be   = 4'b0001 << q_addr[1:0];
            end
            F3_H: begin
                st_data = {2{q_wdata[15:0]}};
                st_be   = q_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Abort on reset even at the commit edge so a reset never leaves a partial store behind.
    assign arr_we = (commit && q_write && !acc_err && !reset) ? st_be : 4'b0000;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .addr (q_addr[ADDR_W+1:WORD_LSB]),
        .wdata(st_data),
        .rdata(rd_word)
    );

    assign rd_shift = rd_word >> {q_addr[1:0], 3'b000};
    assign rd_half  = q_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (q_funct3)
            F3_B:    load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            F3_BU:   load_data = {24'd0, rd_shift[7:0]};
            F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
            F3_HU:   load_data = {16'd0, rd_half};
            default: load_data = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                q_write  <= req_write;
                q_addr   <= req_addr;
                q_wdata  <= req_wdata;
                q_funct3 <= req_funct3;
                cnt      <= CNT_W'(WAIT_CYCLES);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (commit) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || q_write) ? 32'd0 : load_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hold/reset corner sequences,
// randomized traffic against a byte-addressed reference model, and a zero-wait spacing check.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int WC    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_write;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [2:0]  z_req_funct3;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [7:0] mbytes [DEPTH*4];

    typedef struct {
        string       name;
        bit          w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_funct3(z_req_funct3),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: storage as bytes, access size/sign derived from the width code.
    function automatic void model(input bit w, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [2:0] f3, output logic [31:0] rd, output bit e);
        int size;
        bit uns;
        logic [63:0] v;
        uns = (f3 == 3'd4) || (f3 == 3'd5);
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        rd = 32'd0;
        e  = (size == 0) || (w && uns) || (a / 4 >= DEPTH);
        if (!e) e = (a % size) != 0;
        if (e) return;
        if (w) begin
            for (int i = 0; i < size; i++) mbytes[a+i] = wd[8*i +: 8];
            return;
        end
        v = 64'd0;
        for (int i = 0; i < size; i++) v = v | (64'(mbytes[a+i]) << (8*i));
        if (!uns && size < 4 && v[8*size-1]) v = v - (64'd1 << (8*size));
        rd = v[31:0];
    endfunction

    task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input int hold,
                          output logic [31:0] rd, output logic er, output int lat, output bit ok);
        int n;
        ok = 1'b0;
        rd = 'x;
        er = 1'bx;
        lat = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_funct3 = f3;
        rsp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_write = ~w; req_funct3 = $urandom_range(0, 7);
        @(negedge clk);
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            check("rsp_timeout", 32'(rsp_valid), 32'd1);
            return;
        end
        rd = rsp_rdata;
        er = rsp_err;
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                check("hold.valid", 32'(rsp_valid), 32'd1);
                check("hold.rdata", rsp_rdata, rd);
                check("hold.err", 32'(rsp_err), 32'(er));
                check("hold.req_ready", 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check("post.rsp_valid", 32'(rsp_valid), 32'd0);
        check("post.req_ready", 32'(req_ready), 32'd1);
        ok = 1'b1;
    endtask

    task automatic run_check(input string name, input bit w, input logic [31:0] a,
                             input logic [31:0] wd, input logic [2:0] f3, input int hold);
        logic [31:0] erd, rd;
        bit ee, ok;
        logic er;
        int lat;
        model(w, a, wd, f3, erd, ee);
        do_req(w, a, wd, f3, hold, rd, er, lat, ok);
        if (!ok) return;
        check({name, ".rdata"}, rd, erd);
        check({name, ".err"}, 32'(er), 32'(ee));
        check({name, ".latency"}, 32'(lat), 32'(WC + 1));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, erd;
        logic er;
        bit ee, ok, seen;
        int lat, nacc;
        int acc_t[32];

        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
        rsp_ready = 1'b1;
        z_req_valid = 1'b0; z_req_write = 1'b1; z_req_addr = '0; z_req_wdata = '0;
        z_req_funct3 = 3'b010; z_rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset.req_ready", 32'(req_ready), 32'd1);
        check("reset.rsp_rdata", rsp_rdata, 32'd0);
        check("reset.rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;

        // Zero-wait instance with a permanently asserted request.
        z_req_valid = 1'b1;
        nacc = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (z_rsp_valid) begin
                check("zw.rsp_err", 32'(z_rsp_err), 32'd0);
                check("zw.rsp_rdata", z_rsp_rdata, 32'd0);
            end
            if (z_req_ready && z_req_valid) begin
                acc_t[nacc] = cyc;
                nacc++;
            end
        end
        z_req_valid = 1'b0;
        check("zw.accept_count", 32'(nacc), 32'd8);
        for (int i = 1; i < nacc; i++) check("zw.spacing", 32'(acc_t[i] - acc_t[i-1]), 32'd3);

        for (int i = 0; i < DEPTH; i++) run_check("fill", 1'b1, 32'(i * 4), $urandom, 3'b010, 0);

        tbl.push_back('{"sw_deadbeef",  1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        1'b0});
        tbl.push_back('{"lw_10",        1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{"sb_80",        1'b1, 32'h13,  32'hFFFFFF80, 3'b000, 32'h0,        1'b0});
        tbl.push_back('{"lb_13",        1'b0, 32'h13,  32'h0,        3'b000, 32'hFFFFFF80, 1'b0});
        tbl.push_back('{"lbu_13",       1'b0, 32'h13,  32'h0,        3'b100, 32'h00000080, 1'b0});
        tbl.push_back('{"lw_10_b",      1'b0, 32'h10,  32'h0,        3'b010, 32'h80ADBEEF, 1'b0});
        tbl.push_back('{"lw_mis_12",    1'b0, 32'h12,  32'h0,        3'b010, 32'h0,        1'b1});
        tbl.push_back('{"sh_mis_11",    1'b1, 32'h11,  32'hAAAA5555, 3'b001, 32'h0,        1'b1});
        tbl.push_back('{"lw_range",     1'b0, 32'(DEPTH*4), 32'h0,   3'b010, 32'h0,        1'b1});
        tbl.push_back('{"lw_10_c",      1'b0, 32'h10,  32'h0,        3'b010, 32'h80ADBEEF, 1'b0});
        tbl.push_back('{"lh_12",        1'b0, 32'h12,  32'h0,        3'b001, 32'hFFFF80AD, 1'b0});
        tbl.push_back('{"lhu_12",       1'b0, 32'h12,  32'h0,        3'b101, 32'h000080AD, 1'b0});
        tbl.push_back('{"f3_011",       1'b0, 32'h10,  32'h0,        3'b011, 32'h0,        1'b1});
        tbl.push_back('{"store_f3_100", 1'b1, 32'h10,  32'h11111111, 3'b100, 32'h0,        1'b1});
        tbl.push_back('{"sh_12",        1'b1, 32'h12,  32'hFFFF1234, 3'b001, 32'h0,        1'b0});
        tbl.push_back('{"lw_10_d",      1'b0, 32'h10,  32'h0,        3'b010, 32'h1234BEEF, 1'b0});

        foreach (tbl[i]) begin
            model(tbl[i].w, tbl[i].addr, tbl[i].wdata, tbl[i].f3, erd, ee);
            do_req(tbl[i].w, tbl[i].addr, tbl[i].wdata, tbl[i].f3, 0, rd, er, lat, ok);
            if (ok) begin
                check({tbl[i].name, ".rdata"}, rd, tbl[i].exp_rdata);
                check({tbl[i].name, ".err"}, 32'(er), 32'(tbl[i].exp_err));
                check({tbl[i].name, ".latency"}, 32'(lat), 32'(WC + 1));
            end
        end

        run_check("hold5", 1'b0, 32'h10, 32'h0, 3'b010, 5);

        // Reset during the first wait cycle must drop the store and its response.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_funct3 = 3'b010; rsp_ready = 1'b1;
        check("abort.req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("abort.no_response", 32'(seen), 32'd0);
        check("abort.req_ready_after", 32'(req_ready), 32'd1);
        run_check("abort.lw_20", 1'b0, 32'h20, 32'h0, 3'b010, 0);

        for (int i = 0; i < 200; i++) begin
            run_check("rand", 1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH*4 + 15)),
                      $urandom, 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 64, meaning the number of 32-bit storage words.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait states between request acceptance and access commit (legal range 0-15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 The block SHALL have port req_write, input, 1 bit: 1 means store, 0 means load.
REQ-008 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 The block SHALL have port req_funct3, input, 3 bits: RISC-V width code (loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW).
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: a response is presented.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: the initiator accepts the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32 bits: load data, extended per funct3; 0 for stores and errors.
REQ-014 The block SHALL have port rsp_err, output, 1 bit: the request was misaligned, out of range, or had an illegal funct3.

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT and RESP.
REQ-016 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-017 A request SHALL be accepted on a cycle where req_valid and req_ready are both 1; at acceptance the block SHALL capture req_write, req_addr, req_wdata and req_funct3, load the wait counter with WAIT_CYCLES, and move to WAIT.
REQ-018 In WAIT, the counter SHALL decrement each cycle; on the cycle it equals 0, the access SHALL commit and the FSM SHALL move to RESP.
REQ-019 With acceptance at edge T, rsp_valid SHALL first be 1 after edge T+WAIT_CYCLES+1; with WAIT_CYCLES=0, after edge T+1.
REQ-020 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_valid and rsp_ready are both 1, at which point the FSM SHALL return to IDLE.
REQ-021 A new request SHALL NOT be accepted in the same cycle as a response handshake, so the minimum spacing between acceptances is WAIT_CYCLES+3 cycles.
REQ-022 Word index SHALL be req_addr[31:2]; an index of DEPTH_WORDS or above SHALL be an error.
REQ-023 Alignment rules SHALL be: halfword requires addr[0]=0; word requires addr[1:0]=00; any other alignment SHALL be an error.
REQ-024 funct3 values 011, 110 and 111 SHALL be errors, as SHALL 100 and 101 when req_write=1.
REQ-025 A store SHALL update only its addressed byte lanes: SB writes lane addr[1:0] with wdata[7:0]; SH writes lanes addr[1]*2 and addr[1]*2+1 with wdata[15:0]; SW writes all four lanes.
REQ-026 Load data SHALL be selected from the addressed lane(s) and sign-extended for LB and LH, zero-extended for LBU and LHU; LW SHALL return the full word.
REQ-027 An erroring request SHALL modify no storage and SHALL respond with rsp_err=1 and rsp_rdata=0.
REQ-028 req_valid asserted outside IDLE SHALL be ignored; the initiator holds it until accepted.

Reset
REQ-029 While reset=1 at an edge, the FSM SHALL go to IDLE, the counter to 0, rsp_valid to 0, rsp_rdata to 0 and rsp_err to 0; req_ready SHALL be 1 from the following cycle.
REQ-030 Reset asserted in WAIT before the commit cycle SHALL abort the request with no storage write and no response.
REQ-031 Reset SHALL NOT clear storage contents.

Structure
REQ-032 The shared package SHALL hold the funct3 width encodings, the FSM state type, and the error-check constants.
REQ-033 Storage SHALL be a sub-module, dmem_array, with DEPTH_WORDS x 32 bits, 4-bit byte-lane write enable, and combinational read; all protocol logic SHALL stay in dmem_responder.

Verification
REQ-034 Scenario (WAIT_CYCLES=2): SW 0xDEADBEEF to addr 0x10, then LW from 0x10 -> rsp_valid asserted 3 cycles after each acceptance; the load returns 0xDEADBEEF with rsp_err=0.
REQ-035 Scenario: SB 0x80 to addr 0x13, then LB 0x13 and LBU 0x13 -> LB returns 0xFFFFFF80, LBU returns 0x00000080, and LW 0x10 returns 0x80ADBEEF.
REQ-036 Scenario: LW from 0x12, SH to 0x11, and LW from DEPTH_WORDS*4 -> each returns rsp_err=1 and rsp_rdata=0, and a following LW 0x10 shows storage unchanged.
REQ-037 Scenario: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0; rsp_ready=1 -> IDLE on the next cycle.
REQ-038 Scenario: accept SW 0x12345678 to 0x20, then assert reset in the first WAIT cycle -> no response is produced, and a later LW 0x20 returns the prior contents.
REQ-039 Scenario (WAIT_CYCLES=0): back-to-back requests with rsp_ready held at 1 -> acceptances are spaced exactly 3 cycles apart.
